gcd_arbiter: RTL and testbench

//  Shares one gcd unit among N requesters. Round-robin grant; drives the gcd

---
 rtl/gcd_arbiter.sv | 142 ++++++++++++++
 tb/tb_gcd_arbiter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd unit among N requesters; one operation in flight.
// req_ack and gcd_data_rdy one cycle after a grant in IDLE; results are held on rsp_valid until rsp_taken.
module gcd_arbiter #(
  parameter int W       = 16,
  parameter int N       = 4,
  parameter int TMO_CYC = 2**(W+1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_A,
  input  logic [N*W-1:0] req_B,
  output logic [N-1:0]   req_ack,
  output logic [N-1:0]   rsp_valid,
  output logic [W-1:0]   rsp_data,
  input  logic [N-1:0]   rsp_taken,
  output logic           gcd_data_rdy,
  output logic [W-1:0]   gcd_A,
  output logic [W-1:0]   gcd_B,
  input  logic           gcd_result_rdy,
  input  logic [W-1:0]   gcd_result_data,
  output logic           gcd_result_taken,
  output logic           busy,
  output logic           fault
);

  localparam int              PW       = (N > 1) ? $clog2(N) : 1;
  localparam int              TW       = W + 2;
  localparam bit              TMO_EN   = (TMO_CYC != 0);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TMO_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_HOLD  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [PW-1:0]  owner_q, owner_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   res_q, res_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [PW-1:0]  winner;
  logic           any_req;
  logic [N-1:0]   owner_oh;

  // Scan downward so the last hit is the requester closest to ptr.
  always_comb begin
    int idx;
    idx     = 0;
    winner  = '0;
    any_req = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req_valid[idx]) begin
        winner  = PW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign owner_oh = N'(1) << owner_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          owner_d = winner;
          a_d     = req_A[int'(winner)*W +: W];
          b_d     = req_B[int'(winner)*W +: W];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = (&timer_q) ? timer_q : timer_q + TW'(1);
        if (gcd_result_rdy) begin
          res_d   = gcd_result_data;
          state_d = S_DONE;
        end else if (TMO_EN && (timer_q == TMO_LAST)) begin
          state_d = S_FAULT;
        end
      end
      S_DONE: state_d = S_HOLD;
      S_HOLD: begin
        if (rsp_taken[owner_q]) begin
          ptr_d   = (owner_q == PW'(N-1)) ? '0 : owner_q + PW'(1);
          state_d = S_IDLE;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      timer_q <= timer_d;
    end
  end

  // All pulses decode from the registered state, so an async reset clears them at once.
  assign req_ack          = (state_q == S_ISSUE) ? owner_oh : '0;
  assign gcd_data_rdy     = (state_q == S_ISSUE);
  assign gcd_result_taken = (state_q == S_DONE);
  assign rsp_valid        = (state_q == S_DONE || state_q == S_HOLD) ? owner_oh : '0;
  assign rsp_data         = res_q;
  assign gcd_A            = a_q;
  assign gcd_B            = b_q;
  assign busy             = (state_q != S_IDLE);
  assign fault            = (state_q == S_FAULT);

endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: behavioural gcd peer, round-robin/ownership reference model,
// vector table plus directed sequences and randomized traffic.
module tb_gcd_arbiter;
  localparam int W   = 16;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid, req_ack, rsp_valid, rsp_taken;
  logic [N*W-1:0] req_A, req_B;
  logic [W-1:0]   rsp_data, gcd_A, gcd_B, gcd_result_data;
  logic           gcd_data_rdy, gcd_result_rdy, gcd_result_taken, busy, fault;

  always #5 clk = ~clk;

  gcd_arbiter #(.W(W), .N(N), .TMO_CYC(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_A(req_A), .req_B(req_B), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_taken(rsp_taken),
    .gcd_data_rdy(gcd_data_rdy), .gcd_A(gcd_A), .gcd_B(gcd_B),
    .gcd_result_rdy(gcd_result_rdy), .gcd_result_data(gcd_result_data),
    .gcd_result_taken(gcd_result_taken), .busy(busy), .fault(fault)
  );

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] exp; } vec_t;
  vec_t vt[8];

  int errors = 0, checks = 0, cyc = 0;
  // reference model of the arbiter
  int m_ptr = 0, m_owner = 0, done_cnt = 0;
  bit m_busy = 0, in_rsp = 0;
  logic [W-1:0] m_a, m_b, m_exp, rsp_hold;
  logic [W-1:0] rsp_first[N];
  int rsp_cycles, dr_cnt, rt_cnt, hold_left;
  int hold_req[N];
  bit persist[N];
  int acks_log[$];
  int ack_cnt = 0, dr_total = 0, rt_total = 0;
  int issue_cyc = 0, fault_cyc = -1;
  bit rand_mode = 0, noise = 0;
  // behavioural gcd unit
  bit hang = 0, gcd_pend = 0;
  int gcd_cnt = 0, lat_max = 3;
  logic [W-1:0] g_a, g_b;

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    int x, y, t;
    x = a; y = b;
    while (y != 0) begin t = x % y; x = y; y = t; end
    return W'(x);
  endfunction

  function automatic int pick(input logic [N-1:0] rv, input int p);
    for (int k = 0; k < N; k++) if (rv[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_A[i*W +: W] = a;
    req_B[i*W +: W] = b;
    req_valid[i]    = 1'b1;
  endtask

  task automatic step;
    int w;
    @(negedge clk);
    cyc++;
    if (req_ack != '0) begin
      w = pick(req_valid, m_ptr);
      ack_cnt++;
      chk("ack_while_busy", 32'(m_busy), 0);
      chk("ack_winner", 32'(req_ack), (w < 0) ? 0 : (1 << w));
      m_busy = 1; m_owner = (w < 0) ? 0 : w;
      m_a = req_A[m_owner*W +: W]; m_b = req_B[m_owner*W +: W];
      m_exp = gcd_ref(m_a, m_b);
      acks_log.push_back(m_owner);
      dr_cnt = 0; rt_cnt = 0; rsp_cycles = 0;
      hold_left = rand_mode ? int'($urandom_range(0, 3)) : hold_req[m_owner];
      req_valid[m_owner] = 1'b0;
      if (persist[m_owner]) set_req(m_owner, W'($urandom_range(1, 500)), W'($urandom_range(1, 500)));
    end
    if (gcd_data_rdy) begin
      dr_cnt++; dr_total++; issue_cyc = cyc;
      chk("issue_outside_op", 32'(m_busy && !in_rsp), 1);
      chk("gcd_A", 32'(gcd_A), 32'(m_a));
      chk("gcd_B", 32'(gcd_B), 32'(m_b));
    end
    if (gcd_result_taken) begin rt_cnt++; rt_total++; end
    if (fault && fault_cyc < 0) fault_cyc = cyc;
    if (rsp_valid != '0) begin
      rsp_cycles++;
      chk("rsp_owner", 32'(rsp_valid), 1 << m_owner);
      if (!in_rsp) begin
        in_rsp = 1; rsp_hold = rsp_data; rsp_first[m_owner] = rsp_data;
        chk("rsp_data", 32'(rsp_data), 32'(m_exp));
      end else begin
        chk("rsp_stable", 32'(rsp_data), 32'(rsp_hold));
      end
      if (hold_left > 0) begin hold_left--; rsp_taken[m_owner] = 1'b0; end
      else rsp_taken[m_owner] = 1'b1;
    end else if (in_rsp) begin
      in_rsp = 0; m_busy = 0; rsp_taken = '0;
      m_ptr = (m_owner + 1) % N; done_cnt++;
      chk("one_data_rdy", 32'(dr_cnt), 1);
      chk("one_result_taken", 32'(rt_cnt), 1);
    end
    if (noise)
      for (int i = 0; i < N; i++)
        if (!(in_rsp && i == m_owner)) rsp_taken[i] = 1'($urandom_range(0, 1));
    if (rand_mode)
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 7) == 0)
          set_req(i, W'($urandom_range(1, 4000)), W'($urandom_range(1, 4000)));
    // gcd peer: result after a random latency, held until result_taken
    if (gcd_result_taken) gcd_result_rdy = 1'b0;
    if (gcd_pend && !hang) begin
      if (gcd_cnt == 0) begin
        gcd_result_rdy = 1'b1; gcd_result_data = gcd_ref(g_a, g_b); gcd_pend = 0;
      end else gcd_cnt--;
    end
    if (gcd_data_rdy) begin
      gcd_pend = 1; gcd_cnt = $urandom_range(0, lat_max); g_a = gcd_A; g_b = gcd_B;
    end
  endtask

  task automatic wait_done(input string nm, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin step(); n++; end
    chk(nm, 32'(done_cnt >= target), 1);
  endtask

  task automatic drain(input string nm, input int budget);
    int n = 0;
    while ((m_busy || req_valid != '0) && n < budget) begin step(); n++; end
    chk(nm, 32'(m_busy || req_valid != '0), 0);
  endtask

  task automatic clear_model;
    m_ptr = 0; m_busy = 0; in_rsp = 0; gcd_pend = 0; gcd_result_rdy = 1'b0;
    req_valid = '0; rsp_taken = '0; acks_log.delete();
  endtask

  task automatic do_reset;
    @(negedge clk); reset_n = 1'b0; clear_model();
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, acks0, dr0, rt0, exp_seq[4];
    vt[0] = '{16'd48, 16'd18, 16'd6};     vt[1] = '{16'd13, 16'd7, 16'd1};
    vt[2] = '{16'd100, 16'd25, 16'd25};   vt[3] = '{16'd12, 16'd60, 16'd12};
    vt[4] = '{16'd1071, 16'd462, 16'd21}; vt[5] = '{16'd65535, 16'd255, 16'd255};
    vt[6] = '{16'd1, 16'd65535, 16'd1};   vt[7] = '{16'd37, 16'd37, 16'd37};
    exp_seq = '{3, 0, 3, 0};
    reset_n = 1'b0; req_valid = '0; req_A = '0; req_B = '0; rsp_taken = '0;
    gcd_result_rdy = 1'b0; gcd_result_data = '0;
    for (int i = 0; i < N; i++) begin hold_req[i] = 0; persist[i] = 0; rsp_first[i] = '0; end
    #12;
    chk("rst_busy", 32'(busy), 0);          chk("rst_fault", 32'(fault), 0);
    chk("rst_req_ack", 32'(req_ack), 0);    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_data", 32'(rsp_data), 0);  chk("rst_gcd_A", 32'(gcd_A), 0);
    chk("rst_gcd_B", 32'(gcd_B), 0);        chk("rst_data_rdy", 32'(gcd_data_rdy), 0);
    chk("rst_result_taken", 32'(gcd_result_taken), 0);
    @(negedge clk); reset_n = 1'b1;
    step(); step();

    // single requester, ack one cycle after request
    set_req(0, 16'd48, 16'd18);
    step();
    chk("t1_ack_latency", 32'(req_ack), 1);
    wait_done("t1_done", done_cnt + 1, 100);
    chk("t1_result", 32'(rsp_first[0]), 6);
    chk("t1_idle", 32'(busy), 0);

    // all four requesting straight after reset
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, vt[i].a, vt[i].b);
    wait_done("t2_done", done_cnt + 4, 400);
    chk("t2_grants", 32'(acks_log.size()), 4);
    for (int i = 0; i < N && i < acks_log.size(); i++) begin
      chk($sformatf("t2_order%0d", i), 32'(acks_log[i]), i);
      chk($sformatf("t2_result%0d", i), 32'(rsp_first[i]), 32'(vt[i].exp));
    end

    // pointer wrap between two persistent requesters
    acks_log.delete();
    set_req(3, 16'd30, 16'd12);
    n = 0;
    while (acks_log.size() < 1 && n < 20) begin step(); n++; end
    persist[0] = 1; persist[3] = 1;
    set_req(0, 16'd9, 16'd6); set_req(3, 16'd8, 16'd12);
    n = 0;
    while (acks_log.size() < 4 && n < 500) begin step(); n++; end
    persist[0] = 0; persist[3] = 0;
    drain("t3_drain", 500);
    chk("t3_grants", 32'(acks_log.size() >= 4), 1);
    for (int i = 0; i < 4 && i < acks_log.size(); i++)
      chk($sformatf("t3_order%0d", i), 32'(acks_log[i]), exp_seq[i]);

    // vector table, one requester at a time
    for (int k = 0; k < 8; k++) begin
      set_req(k % N, vt[k].a, vt[k].b);
      wait_done($sformatf("vec%0d_done", k), done_cnt + 1, 200);
      chk($sformatf("vec%0d", k), 32'(rsp_first[k % N]), 32'(vt[k].exp));
    end

    // consumer stalls for 20 cycles with another request pending
    hold_req[1] = 20;
    set_req(1, 16'd21, 16'd14);
    n = 0;
    while (!m_busy && n < 10) begin step(); n++; end
    acks0 = ack_cnt; dr0 = dr_total;
    set_req(2, 16'd9, 16'd6);
    wait_done("t4_done1", done_cnt + 1, 200);
    chk("t4_hold_cycles", 32'(rsp_cycles >= 21), 1);
    chk("t4_no_ack_during_hold", 32'(ack_cnt - acks0), 0);
    chk("t4_no_issue_during_hold", 32'(dr_total - dr0), 0);
    hold_req[1] = 0;
    wait_done("t4_done2", done_cnt + 1, 200);
    chk("t4_next_owner", 32'(acks_log[$]), 2);

    // randomized traffic with stray rsp_taken bits
    base = done_cnt;
    rand_mode = 1; noise = 1; lat_max = 5;
    repeat (2500) step();
    rand_mode = 0; noise = 0; rsp_taken = '0;
    drain("rand_drain", 1000);
    chk("rand_progress", 32'(done_cnt - base > 20), 1);

    // async reset in the middle of WAIT clears pointer and outputs
    lat_max = 3;
    set_req(2, 16'd8, 16'd4);
    wait_done("t6_pre", done_cnt + 1, 100);
    hang = 1;
    set_req(3, 16'd55, 16'd77);
    n = 0;
    while (!m_busy && n < 10) begin step(); n++; end
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 0);          chk("t6_gcd_A", 32'(gcd_A), 0);
    chk("t6_gcd_B", 32'(gcd_B), 0);        chk("t6_req_ack", 32'(req_ack), 0);
    chk("t6_rsp_valid", 32'(rsp_valid), 0); chk("t6_data_rdy", 32'(gcd_data_rdy), 0);
    clear_model(); hang = 0;
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    set_req(1, 16'd37, 16'd37); set_req(3, 16'd37, 16'd37);
    wait_done("t6_done", done_cnt + 1, 100);
    chk("t6_first_grant", 32'(acks_log.size() > 0 ? acks_log[0] : -1), 1);
    chk("t6_result", 32'(rsp_first[1]), 37);
    drain("t6_drain", 200);

    // gcd never answers: timeout fault, then nothing more is granted
    hang = 1; fault_cyc = -1;
    set_req(0, 16'd5, 16'd10);
    n = 0;
    while (fault_cyc < 0 && n < 300) begin step(); n++; end
    chk("t5_fault_seen", 32'(fault_cyc >= 0), 1);
    chk("t5_fault_delay", 32'((fault_cyc - issue_cyc) inside {64, 65}), 1);
    chk("t5_busy", 32'(busy), 1);
    acks0 = ack_cnt; dr0 = dr_total; rt0 = rt_total;
    for (int i = 0; i < N; i++) set_req(i, 16'd3, 16'd9);
    repeat (40) step();
    chk("t5_no_ack", 32'(ack_cnt - acks0), 0);
    chk("t5_no_data_rdy", 32'(dr_total - dr0), 0);
    chk("t5_no_result_taken", 32'(rt_total - rt0), 0);
    chk("t5_sticky", 32'(fault), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
